recurrence_sequencer: RTL and testbench
=======================================

# recurrence_sequencer

Controller that sequences the four-register recurrence datapath (a←b+c, d←a−3, b←d+10, c←c+1) for a programmed number of iterations, in either of two update disciplines. In sequential mode each register updates on its own clock edge, in a−d−b−c order, using the newest values. In parallel mode all four registers update on the same edge from the old values. The block sits between a host issuing start/done transactions and the recurrence register file, and it owns those registers.

## Interface
- WIDTH, 32: width of each datapath register; two's-complement signed view.
- ITER_W, 4: width of the iteration count.
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = sequential (four phases per iteration), 1 = parallel (one edge per iteration); sampled with start.
- iterations  input  ITER_W  iteration count N; sampled with start.
- init_a, init_b, init_c, init_d  input  WIDTH each  initial register values; sampled with start.
- busy  output  1  high while updates are pending.
- done  output  1  one-cycle completion pulse.
- phase  output  2  current sequential phase: 0=A, 1=D, 2=B, 3=C; 0 in parallel mode and IDLE.
- iter_left  output  ITER_W  iterations not yet completed.
- a, b, c, d  output  WIDTH each  datapath registers.

## Operation
- FSM states: IDLE, SEQ, PAR.
- IDLE with start=1 at edge k:
  - load a..d from init_*; latch mode; set iter_left=N, phase=0.
  - N=0: stay in IDLE, pulse done after edge k, busy stays 0.
  - N>0: go to SEQ (mode=0) or PAR (mode=1); busy=1 after edge k.
- SEQ, one register per edge, wrapping phase 3→0:
  - phase A: a←b+c
  - phase D: d←a−3
  - phase B: b←d+10
  - phase C: c←c+1; iter_left decrements.
  - Each phase uses the values left by the previous phase.
- PAR, per edge:
  - a←b+c, d←a−3, b←d+10, c←c+1, all from pre-edge values.
  - iter_left decrements.
- Final update edge (iter_left 1→0): go to IDLE, busy=0, done=1 for the following cycle only, phase=0.
- start while busy is ignored. Changes to mode, iterations or init_* after sampling have no effect.
- Arithmetic:
  - Results are modulo 2^WIDTH; wrap silently, no saturation and no overflow flag.
  - The constants 3 and 10 are sign-extended to WIDTH.
- Registers hold their value in IDLE, including after done.
- Reset values: a=b=c=d=0, busy=0, done=0, phase=0, iter_left=0, state IDLE.
- reset_n low mid-run: immediate asynchronous return to reset values; no done pulse.

## Timing
- Sequential latency: load edge plus 4N update edges; done is high in the cycle after edge 4N past the load edge.
- Parallel latency: load edge plus N update edges.
- Back-to-back runs: start may be high in the same cycle as done; it is sampled, because the FSM is in IDLE during the done cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- RSEQ_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in SEQ or PAR: at the next edge go to IDLE, busy=0, iter_left=0, phase=0.
  - a..d keep the values they held just before that edge; the abort edge performs no update.
  - No done pulse on abort.
  - abort in IDLE has no effect, and abort takes priority over the step on the same edge.
- RSEQ_ABORT_EN undefined: no abort port; a run ends only on completion or reset.

## Test plan
- Sequential, N=1, init a=30 b=20 c=15 d=5 → after 4 update edges a=35 d=32 b=42 c=16; done pulses exactly once, 5 cycles after the start edge.
- Sequential, N=2, same init → a=58 b=65 c=17 d=55; phase sequence 0,1,2,3,0,1,2,3; iter_left steps 2→1→0.
- Parallel, N=2, same init → after edge 1 a=35 b=15 c=16 d=27; after edge 2 a=31 b=37 c=17 d=32; done high in the cycle after edge 2.
- N=0 with init 7,8,9,10 → registers load 7,8,9,10; done pulses after the load edge; busy never rises.
- Wrap and ignored start: WIDTH=32, init b=32'h7FFFFFFF c=1, parallel N=1 → a=32'h80000000; a start pulse during busy is ignored; reset_n pulsed low mid-run clears all outputs to 0 with no done.
- RSEQ_ABORT_EN: sequential N=3, assert abort during phase B of iteration 2 → IDLE next edge, b unchanged by that edge, no done; a following start runs normally.

Source files
------------

// File: rtl/recurrence_sequencer_if.sv
// Host-side bus of the recurrence sequencer: start/done handshake, run
// parameters and the observable datapath registers.
// Optional abort input is present when RSEQ_ABORT_EN is defined.
interface recurrence_sequencer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ITER_W = 4
);
    logic              start;
    logic              mode;
    logic [ITER_W-1:0] iterations;
    logic [WIDTH-1:0]  init_a;
    logic [WIDTH-1:0]  init_b;
    logic [WIDTH-1:0]  init_c;
    logic [WIDTH-1:0]  init_d;
    logic              busy;
    logic              done;
    logic [1:0]        phase;
    logic [ITER_W-1:0] iter_left;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  c;
    logic [WIDTH-1:0]  d;
`ifdef RSEQ_ABORT_EN
    logic              abort;

    modport master (
        output start, mode, iterations, init_a, init_b, init_c, init_d, abort,
        input  busy, done, phase, iter_left, a, b, c, d
    );

    modport slave (
        input  start, mode, iterations, init_a, init_b, init_c, init_d, abort,
        output busy, done, phase, iter_left, a, b, c, d
    );
`else
    modport master (
        output start, mode, iterations, init_a, init_b, init_c, init_d,
        input  busy, done, phase, iter_left, a, b, c, d
    );

    modport slave (
        input  start, mode, iterations, init_a, init_b, init_c, init_d,
        output busy, done, phase, iter_left, a, b, c, d
    );
`endif
endinterface

// File: rtl/recurrence_sequencer.sv
// Sequences the recurrence a<-b+c, d<-a-3, b<-d+10, c<-c+1 for N iterations,
// either one register per edge (sequential, phases A-D-B-C) or all four per
// edge (parallel). Owns the four datapath registers.
// Optional feature: define RSEQ_ABORT_EN to add an abort input that ends a
// run at the next edge without updating the registers and without done.
module recurrence_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ITER_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    recurrence_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEQ  = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam logic [1:0]       PH_A = 2'd0;
    localparam logic [1:0]       PH_D = 2'd1;
    localparam logic [1:0]       PH_B = 2'd2;
    localparam logic [WIDTH-1:0] K3   = WIDTH'(3);
    localparam logic [WIDTH-1:0] K10  = WIDTH'(10);
    localparam logic [WIDTH-1:0] K1   = WIDTH'(1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [1:0]        phase_q, phase_d;
    logic [ITER_W-1:0] iter_left_q, iter_left_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abort_c;
    logic              last_iter_c;

`ifdef RSEQ_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    assign last_iter_c = (iter_left_q == ITER_W'(1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: leave IDLE on a non-empty request, return on last step or abort
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.iterations != '0))
                    state_d = bus.mode ? ST_PAR : ST_SEQ;
            end
            ST_SEQ: begin
                if (abort_c)                                  state_d = ST_IDLE;
                else if ((phase_q == 2'd3) && last_iter_c)    state_d = ST_IDLE;
            end
            ST_PAR: begin
                if (abort_c || last_iter_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything below is registered
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        phase_d     = phase_q;
        iter_left_d = iter_left_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d         = bus.init_a;
                    b_d         = bus.init_b;
                    c_d         = bus.init_c;
                    d_d         = bus.init_d;
                    iter_left_d = bus.iterations;
                    phase_d     = PH_A;
                    busy_d      = (bus.iterations != '0);
                    done_d      = (bus.iterations == '0);
                end
            end
            ST_SEQ: begin
                if (abort_c) begin
                    busy_d      = 1'b0;
                    iter_left_d = '0;
                    phase_d     = PH_A;
                end else begin
                    case (phase_q)
                        PH_A:    a_d = b_q + c_q;
                        PH_D:    d_d = a_q - K3;
                        PH_B:    b_d = d_q + K10;
                        default: begin
                            c_d         = c_q + K1;
                            iter_left_d = iter_left_q - ITER_W'(1);
                            if (last_iter_c) begin
                                busy_d = 1'b0;
                                done_d = 1'b1;
                            end
                        end
                    endcase
                    // Phase C wraps back to A, which is also the idle value
                    phase_d = phase_q + 2'd1;
                end
            end
            ST_PAR: begin
                if (abort_c) begin
                    busy_d      = 1'b0;
                    iter_left_d = '0;
                    phase_d     = PH_A;
                end else begin
                    a_d         = b_q + c_q;
                    d_d         = a_q - K3;
                    b_d         = d_q + K10;
                    c_d         = c_q + K1;
                    iter_left_d = iter_left_q - ITER_W'(1);
                    if (last_iter_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d      = 1'b0;
                iter_left_d = '0;
                phase_d     = PH_A;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            phase_q     <= PH_A;
            iter_left_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            phase_q     <= phase_d;
            iter_left_q <= iter_left_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign bus.phase     = phase_q;
    assign bus.iter_left = iter_left_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_recurrence_sequencer.sv
// Self-checking bench for recurrence_sequencer: directed test-plan cases plus
// random runs compared cycle by cycle against a trace-building reference model.
// Exercises the abort path when RSEQ_ABORT_EN is defined.
module tb_recurrence_sequencer;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 4;

    typedef struct {
        logic [W-1:0]  a, b, c, d;
        logic [1:0]    phase;
        logic [IW-1:0] iter;
        logic          busy, done;
    } snap_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];

    recurrence_sequencer_if #(.WIDTH(W), .ITER_W(IW)) bus();

    recurrence_sequencer #(.WIDTH(W), .ITER_W(IW)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag, input snap_t e);
        check({tag, ".a"},    64'(bus.a),         64'(e.a));
        check({tag, ".b"},    64'(bus.b),         64'(e.b));
        check({tag, ".c"},    64'(bus.c),         64'(e.c));
        check({tag, ".d"},    64'(bus.d),         64'(e.d));
        check({tag, ".phase"},64'(bus.phase),     64'(e.phase));
        check({tag, ".iter"}, 64'(bus.iter_left), 64'(e.iter));
        check({tag, ".busy"}, 64'(bus.busy),      64'(e.busy));
        check({tag, ".done"}, 64'(bus.done),      64'(e.done));
    endtask

    // Expected outputs after each edge: index 0 = load edge, last = idle hold
    task automatic build_model(input logic m, input int n,
                               input logic [W-1:0] ia, ib, ic, id);
        snap_t s;
        logic [W-1:0] na, nb, nc, nd;
        bit last;
        exp_q.delete();
        s.a = ia; s.b = ib; s.c = ic; s.d = id;
        s.phase = 2'd0; s.iter = IW'(n); s.busy = (n != 0); s.done = (n == 0);
        exp_q.push_back(s);
        for (int it = 0; it < n; it++) begin
            if (!m) begin
                for (int p = 0; p < 4; p++) begin
                    case (p)
                        0:       s.a = s.b + s.c;
                        1:       s.d = s.a - W'(3);
                        2:       s.b = s.d + W'(10);
                        default: s.c = s.c + W'(1);
                    endcase
                    last    = (it == n - 1) && (p == 3);
                    s.phase = 2'((p + 1) % 4);
                    s.iter  = IW'(n - it - ((p == 3) ? 1 : 0));
                    s.busy  = !last;
                    s.done  = last;
                    exp_q.push_back(s);
                end
            end else begin
                na = s.b + s.c; nd = s.a - W'(3); nb = s.d + W'(10); nc = s.c + W'(1);
                s.a = na; s.b = nb; s.c = nc; s.d = nd;
                last    = (it == n - 1);
                s.phase = 2'd0;
                s.iter  = IW'(n - it - 1);
                s.busy  = !last;
                s.done  = last;
                exp_q.push_back(s);
            end
        end
        s.busy = 1'b0; s.done = 1'b0; s.phase = 2'd0; s.iter = '0;
        exp_q.push_back(s);
    endtask

    task automatic scramble_inputs(input logic nonzero_n);
        bus.mode       = 1'($urandom);
        bus.iterations = nonzero_n ? IW'($urandom_range(1, 15)) : IW'($urandom);
        bus.init_a     = $urandom;
        bus.init_b     = $urandom;
        bus.init_c     = $urandom;
        bus.init_d     = $urandom;
    endtask

    // Issue one run; poke>=0 raises start for one edge after that trace index;
    // b2b returns in the done cycle so the next run's start overlaps done.
    task automatic run_case(input string tag, input logic m, input int n,
                            input logic [W-1:0] ia, ib, ic, id,
                            input int poke, input bit b2b);
        int last;
        build_model(m, n, ia, ib, ic, id);
        bus.start = 1'b1; bus.mode = m; bus.iterations = IW'(n);
        bus.init_a = ia; bus.init_b = ib; bus.init_c = ic; bus.init_d = id;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble_inputs(1'b0);
        compare($sformatf("%s[0]", tag), exp_q[0]);
        last = b2b ? exp_q.size() - 1 : exp_q.size();
        for (int k = 1; k < last; k++) begin
            if (poke >= 0 && k - 1 == poke) begin
                bus.start = 1'b1;
                scramble_inputs(1'b1);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            compare($sformatf("%s[%0d]", tag, k), exp_q[k]);
        end
    endtask

    initial begin
        snap_t hold;
        bus.start = 1'b0; bus.mode = 1'b0; bus.iterations = '0;
        bus.init_a = '0; bus.init_b = '0; bus.init_c = '0; bus.init_d = '0;
`ifdef RSEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        hold = '{a: '0, b: '0, c: '0, d: '0, phase: 2'd0, iter: '0, busy: 1'b0, done: 1'b0};
        compare("reset", hold);
        rst_n = 1'b1;
        @(posedge clk); #1;
        compare("post_reset", hold);

        // Test-plan directed runs; first two back-to-back (start during done)
        run_case("seq_n1", 1'b0, 1, 30, 20, 15, 5, -1, 1'b1);
        run_case("seq_n2", 1'b0, 2, 30, 20, 15, 5, -1, 1'b0);
        run_case("par_n2", 1'b1, 2, 30, 20, 15, 5, -1, 1'b0);
        run_case("n0",     1'b0, 0, 7, 8, 9, 10, -1, 1'b0);
        run_case("wrap",   1'b1, 1, 0, 32'h7FFF_FFFF, 1, 0, 0, 1'b0);
        check("wrap.a_literal", 64'(bus.a), 64'h8000_0000);
        run_case("seq_ign", 1'b0, 3, 1, 2, 3, 4, 5, 1'b0);
        run_case("par_ign", 1'b1, 5, 9, 9, 9, 9, 2, 1'b0);

        // Random runs with a start poke somewhere inside the busy window
        for (int r = 0; r < 8; r++) begin
            logic m;
            int   n, steps;
            m     = 1'($urandom);
            n     = $urandom_range(0, 6);
            steps = m ? n : 4 * n;
            run_case($sformatf("rnd%0d", r), m, n, $urandom, $urandom, $urandom, $urandom,
                     (n > 0) ? int'($urandom_range(0, steps - 1)) : -1, 1'($urandom));
        end
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a run: clears at once, no done
        build_model(1'b0, 5, 11, 22, 33, 44);
        bus.start = 1'b1; bus.mode = 1'b0; bus.iterations = IW'(5);
        bus.init_a = 11; bus.init_b = 22; bus.init_c = 33; bus.init_d = 44;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
        end
        compare("rst_mid.pre", exp_q[6]);
        #2 rst_n = 1'b0;
        #1 compare("rst_mid.async", hold);
        @(posedge clk); #1;
        compare("rst_mid.held", hold);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            compare($sformatf("rst_mid.after%0d", k), hold);
        end

`ifdef RSEQ_ABORT_EN
        // Abort during phase B of iteration 2 (trace index 6)
        build_model(1'b0, 3, 30, 20, 15, 5);
        bus.start = 1'b1; bus.mode = 1'b0; bus.iterations = IW'(3);
        bus.init_a = 30; bus.init_b = 20; bus.init_c = 15; bus.init_d = 5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
        end
        compare("abort.pre", exp_q[6]);
        hold = exp_q[6];
        hold.busy = 1'b0; hold.done = 1'b0; hold.phase = 2'd0; hold.iter = '0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        compare("abort.edge", hold);
        @(posedge clk); #1;
        compare("abort.idle", hold);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        compare("abort.in_idle", hold);
        run_case("after_abort", 1'b0, 1, 30, 20, 15, 5, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
